board_number_encoder: RTL and testbench
=======================================

Name: board_number_encoder

Overview:
- Builds the per-cell state words that the tile glyph lookup consumes.
- After a new mine map is placed, it scans the board in row-major order. For each cell it counts the mines among its 8 neighbours.
- Writes one 5-bit cell word {flag, mine, number[2:0]} per cell into the cell-state RAM, then signals done so gameplay can begin.

Parameters:
- COLS, 16, board width in cells.
- ROWS, 16, board height in cells.
- AW, $clog2(COLS*ROWS), address width; derived, not overridden.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to encode the whole board.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when the last cell word has been written.
- mine_re  out  1  mine-map read enable.
- mine_addr  out  AW  mine-map read address, y*COLS+x.
- mine_rdata  in  1  mine bit; valid the cycle after mine_re.
- cell_we  out  1  cell-state RAM write enable.
- cell_addr  out  AW  cell-state write address, y*COLS+x.
- cell_wdata  out  5  {flag, mine, number[2:0]}.
- mine_total  out  AW+1  count of mine cells written in the current or last scan.
- sat_seen  out  1  sticky: a neighbour count of 8 was saturated to 7.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; busy, done, mine_re, cell_we, sat_seen = 0; mine_addr, cell_addr, cell_wdata, mine_total = 0; cell counters x=y=0.
- States: IDLE -> SCAN -> WRITE -> (SCAN for the next cell | DONE) -> IDLE.
- IDLE:
  - start=1 at a rising edge is accepted: clear x, y, mine_total, sat_seen; go to SCAN.
  - start in any other state is ignored.
- SCAN, slot counter k=0..9, one cycle per k:
  - Slot order for k=0..8, as (dx,dy): (-1,-1) (0,-1) (1,-1) (-1,0) (0,0) (1,0) (-1,1) (0,1) (1,1).
  - In cycle k<9, if (x+dx, y+dy) is in bounds: mine_re=1, mine_addr = that address. Otherwise mine_re=0, mine_addr=0.
  - A valid bit is pipelined alongside each read.
  - In cycle k+1, if the valid bit is set, mine_rdata is accumulated. Slot 4 (0,0) loads self_mine; all other slots add to a 4-bit count.
  - Cycle k=9 only drains the last read. It then goes to WRITE.
- WRITE, one cycle:
  - cell_we=1, cell_addr = y*COLS+x.
  - cell_wdata = {1'b0, self_mine, self_mine ? 3'd0 : min(count,7)}.
  - If a non-mine count equals 8: write 3'd7 and set sat_seen.
  - mine_total increments if self_mine.
  - Advance x; on x=COLS-1 wrap x to 0 and increment y. After the cell at (COLS-1, ROWS-1), go to DONE; otherwise go to SCAN with k=0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Timing:
  - Every cell takes exactly 11 cycles regardless of edge position.
  - busy is high from the cycle after start through the final WRITE.
  - done comes 11*COLS*ROWS+1 cycles after the start edge; 2817 for 16x16.
- Outputs:
  - cell_we is high only in WRITE.
  - Out-of-bounds neighbours never issue reads and never count.
  - The flag bit is always written 0 (fresh board).
- Reset mid-scan: immediate abort, no further writes, no done. Partially written RAM content is left as-is; the next start rewrites every cell.
- mine_total and sat_seen hold their values in IDLE until the next accepted start.

Decomposition:
- minesweeper_pkg holds:
  - cell_t, a packed struct {flag, mine, number[2:0]}, shared with the glyph lookup.
  - Default COLS/ROWS constants.
  - The 9-entry dx/dy offset table.
  - The state enum.
- One combinational sub-module, neighbor_addr_gen: inputs (x, y, k), outputs (addr, in_bounds, is_self).

Test Plan:
- Empty 16x16 map, start -> 256 writes, all cell_wdata=5'b00000, addresses 0..255 in order; done at cycle 2817; mine_total=0; sat_seen=0.
- Single mine at (0,0):
  - cell 0 = 5'b01000; cells 1, 16, 17 = 5'b00001; all others = 5'b00000; mine_total=1.
  - No mine_re for x=-1 or y=-1 slots.
- Mines at (1,0), (0,1), (1,1) -> cell (0,0) = 5'b00011; cell (2,2) = 5'b00001; mine_total=3.
- 8 mines ringing (7,7), centre empty:
  - cell 119 = 5'b00111, sat_seen=1.
  - Each ring cell's word has mine=1, number=0.
- All-mine map -> every write = 5'b01000, mine_total=256, sat_seen=0.
- start during busy at cycle 100 -> ignored, single done at 2817.
- Reset_n=0 at cycle 500 -> busy=0 and cell_we=0 asynchronously, no done; a new start afterwards completes with correct words.

Source files
------------

// File: rtl/minesweeper_pkg.sv
// Shared Minesweeper definitions.
// Contents:
//   - cell_t: the per-cell state word {flag, mine, number[2:0]}, also read by the
//     tile glyph lookup.
//   - DEF_COLS / DEF_ROWS: default board size.
//   - SLOT_DX / SLOT_DY: neighbour offsets in slot order k = 0..8, row-major
//     around the centre cell. Slot 4 is the cell itself.
//   - state_e: the encoder FSM states.
package minesweeper_pkg;

  localparam int DEF_COLS = 16;
  localparam int DEF_ROWS = 16;

  typedef struct packed {
    logic       flag;
    logic       mine;
    logic [2:0] number;
  } cell_t;

  // Offsets for slots k = 0..8:
  // (-1,-1) (0,-1) (1,-1) (-1,0) (0,0) (1,0) (-1,1) (0,1) (1,1)
  localparam int SLOT_DX [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam int SLOT_DY [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam logic [3:0] SELF_SLOT = 4'd4;
  localparam logic [3:0] LAST_SLOT = 4'd9;  // drain-only slot, no read issued

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int slot_dx(input logic [3:0] k);
    int r;
    r = 0;
    if (k < LAST_SLOT) r = SLOT_DX[k];
    return r;
  endfunction

  function automatic int slot_dy(input logic [3:0] k);
    int r;
    r = 0;
    if (k < LAST_SLOT) r = SLOT_DY[k];
    return r;
  endfunction

endpackage

// File: rtl/neighbor_addr_gen.sv
// Combinational neighbour address generator.
// Given the centre cell (x_i, y_i) and the slot number k_i, produces the
// mine-map address of that neighbour, whether it lies on the board, and
// whether the slot is the centre cell itself.
// Ports:
//   x_i, y_i     centre cell coordinates
//   k_i          slot 0..9 (slot 9 never addresses a cell)
//   addr_o       y*COLS+x of the neighbour, 0 when out of bounds
//   in_bounds_o  neighbour exists on the board
//   is_self_o    slot is the centre cell
module neighbor_addr_gen
  import minesweeper_pkg::*;
#(
  parameter int  COLS = DEF_COLS,
  parameter int  ROWS = DEF_ROWS,
  localparam int AW   = $clog2(COLS * ROWS),
  localparam int XW   = $clog2(COLS),
  localparam int YW   = $clog2(ROWS)
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic [3:0]    k_i,
  output logic [AW-1:0] addr_o,
  output logic          in_bounds_o,
  output logic          is_self_o
);

  int nx;
  int ny;

  always_comb begin
    nx          = int'(x_i) + slot_dx(k_i);
    ny          = int'(y_i) + slot_dy(k_i);
    in_bounds_o = (k_i < LAST_SLOT) && (nx >= 0) && (nx < COLS) &&
                  (ny >= 0) && (ny < ROWS);
    addr_o      = '0;
    if (in_bounds_o) addr_o = AW'(ny * COLS + nx);
    is_self_o   = (k_i == SELF_SLOT);
  end

endmodule

// File: rtl/board_number_encoder.sv
// Board number encoder.
// After a new mine map is placed, walks every cell in row-major order, reads
// the cell and its in-bounds neighbours from the mine map (one read per cycle,
// 1-cycle read latency), and writes {flag=0, mine, number} into the cell-state
// RAM. Every cell takes 11 cycles: 10 SCAN cycles (9 read slots + 1 drain)
// and 1 WRITE cycle.
// Handshake: start is a single-cycle request accepted only in IDLE and
// ignored in every other state; completion is the one-cycle done pulse.
// Ports:
//   Clk, Reset_n  clock, asynchronous active-low reset
//   start         encode request
//   busy, done    scan in progress / one-cycle completion pulse
//   mine_re, mine_addr, mine_rdata   mine-map read port
//   cell_we, cell_addr, cell_wdata   cell-state RAM write port
//   mine_total    mines written in the current or last scan
//   sat_seen      sticky: a count of 8 was written as 7
//   dbg_state     current FSM state (state_e encoding)
module board_number_encoder
  import minesweeper_pkg::*;
#(
  parameter int  COLS = DEF_COLS,
  parameter int  ROWS = DEF_ROWS,
  localparam int AW   = $clog2(COLS * ROWS),
  localparam int XW   = $clog2(COLS),
  localparam int YW   = $clog2(ROWS)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mine_re,
  output logic [AW-1:0] mine_addr,
  input  logic          mine_rdata,
  output logic          cell_we,
  output logic [AW-1:0] cell_addr,
  output logic [4:0]    cell_wdata,
  output logic [AW:0]   mine_total,
  output logic          sat_seen,
  output logic [1:0]    dbg_state
);

  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  state_e        state_q, state_d;
  logic [3:0]    k_q, k_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          self_q, self_d;
  logic          rd_valid_q, rd_valid_d;  // a read was issued last cycle
  logic          rd_self_q, rd_self_d;    // ...and it was the centre cell
  logic [AW:0]   total_q, total_d;
  logic          sat_q, sat_d;

  logic [AW-1:0] nb_addr;
  logic          nb_in_bounds;
  logic          nb_is_self;
  cell_t         cell_word;

  neighbor_addr_gen #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_nb (
    .x_i        (x_q),
    .y_i        (y_q),
    .k_i        (k_q),
    .addr_o     (nb_addr),
    .in_bounds_o(nb_in_bounds),
    .is_self_o  (nb_is_self)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    self_d     = self_q;
    total_d    = total_q;
    sat_d      = sat_q;
    rd_valid_d = 1'b0;
    rd_self_d  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    mine_re    = 1'b0;
    mine_addr  = '0;
    cell_we    = 1'b0;
    cell_addr  = '0;
    cell_wdata = '0;
    cell_word  = '0;

    // Read data returns one cycle after its request; fold it in here.
    if (rd_valid_q) begin
      if (rd_self_q) self_d = mine_rdata;
      else           cnt_d  = cnt_q + {3'b000, mine_rdata};
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          k_d     = '0;
          cnt_d   = '0;
          self_d  = 1'b0;
          total_d = '0;
          sat_d   = 1'b0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        busy       = 1'b1;
        mine_re    = nb_in_bounds;
        mine_addr  = nb_addr;
        rd_valid_d = nb_in_bounds;
        rd_self_d  = nb_is_self;
        if (k_q == LAST_SLOT) state_d = ST_WRITE;
        else                  k_d     = k_q + 4'd1;
      end

      ST_WRITE: begin
        busy           = 1'b1;
        cell_we        = 1'b1;
        cell_addr      = AW'(int'(y_q) * COLS + int'(x_q));
        cell_word.flag = 1'b0;
        cell_word.mine = self_q;
        if (self_q) begin
          cell_word.number = 3'd0;
        end else if (cnt_q[3]) begin
          // Only 3 bits of number: a full ring of 8 shows as 7.
          cell_word.number = 3'd7;
          sat_d            = 1'b1;
        end else begin
          cell_word.number = cnt_q[2:0];
        end
        cell_wdata = cell_word;
        if (self_q) total_d = total_q + {{AW{1'b0}}, 1'b1};

        k_d    = '0;
        cnt_d  = '0;
        self_d = 1'b0;
        state_d = ST_SCAN;
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            state_d = ST_DONE;
          end else begin
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      self_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_self_q  <= 1'b0;
      total_q    <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      self_q     <= self_d;
      rd_valid_q <= rd_valid_d;
      rd_self_q  <= rd_self_d;
      total_q    <= total_d;
      sat_q      <= sat_d;
    end
  end

  assign mine_total = total_q;
  assign sat_seen   = sat_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_board_number_encoder.sv
// Directed testbench for board_number_encoder (16x16 board).
// A behavioural mine-map RAM answers reads one cycle later; every cell write
// is checked against an expected queue built from an independent neighbour
// count of the bench's map, and selected cells are checked against
// hand-computed words.
module tb_board_number_encoder;

  localparam int AW = 8;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          mine_re;
  logic [AW-1:0] mine_addr;
  logic          mine_rdata = 1'b0;
  logic          cell_we;
  logic [AW-1:0] cell_addr;
  logic [4:0]    cell_wdata;
  logic [AW:0]   mine_total;
  logic          sat_seen;
  logic [1:0]    dbg_state;

  board_number_encoder dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mine_re   (mine_re),
    .mine_addr (mine_addr),
    .mine_rdata(mine_rdata),
    .cell_we   (cell_we),
    .cell_addr (cell_addr),
    .cell_wdata(cell_wdata),
    .mine_total(mine_total),
    .sat_seen  (sat_seen),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  // ---------------- mine map model ----------------
  logic map [256];
  always @(posedge Clk) mine_rdata <= mine_re ? map[mine_addr] : 1'b0;

  // ---------------- scoreboard ----------------
  int            checks   = 0;
  int            failures = 0;
  int            reads    = 0;
  int            done_cnt = 0;
  logic [12:0]   exp_q[$];     // {addr, word}
  logic [4:0]    got [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_word(input int x, input int y);
    int n;
    n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (!(dx == 0 && dy == 0) && (x + dx >= 0) && (x + dx < 16) &&
            (y + dy >= 0) && (y + dy < 16) && map[(y + dy) * 16 + x + dx])
          n++;
    if (map[y * 16 + x]) return 5'b01000;
    if (n > 7) n = 7;
    return {2'b00, 3'(n)};
  endfunction

  always @(negedge Clk) begin
    if (mine_re) reads++;
    if (done) done_cnt++;
    if (cell_we) begin
      logic [12:0] e;
      got[cell_addr] = cell_wdata;
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(cell_addr), 32'(e[12:5]));
        chk("write_word", 32'(cell_wdata), 32'(e[4:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_map();
    for (int i = 0; i < 256; i++) map[i] = 1'b0;
  endtask

  // Runs one scan. poke_cyc: cycle at which a stray start is pulsed (0=none).
  // abort_cyc: cycle at which reset is asserted (0=none).
  task automatic do_scan(input string tag, input int poke_cyc, input int abort_cyc,
                         input int exp_total, input logic exp_sat);
    int cyc;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({8'(i), model_word(i % 16, i / 16)});
      got[i] = 5'h1f;
    end
    reads    = 0;
    done_cnt = 0;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    while (!done && cyc < 4000) begin
      start = (cyc == poke_cyc);
      if (cyc == abort_cyc) begin
        Reset_n = 1'b0;
        #1;
        chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
        chk({tag, "_abort_we"}, 32'(cell_we), 32'd0);
        chk({tag, "_abort_re"}, 32'(mine_re), 32'd0);
        repeat (20) @(posedge Clk);
        #2;
        chk({tag, "_abort_no_done"}, 32'(done_cnt), 32'd0);
        chk({tag, "_abort_total"}, 32'(mine_total), 32'd0);
        Reset_n = 1'b1;
        exp_q.delete();
        return;
      end
      @(posedge Clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 32'(cyc), 32'd2817);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    repeat (5) @(posedge Clk);
    #1;
    chk({tag, "_single_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_read_count"}, 32'(reads), 32'd2116);
    chk({tag, "_mine_total"}, 32'(mine_total), 32'(exp_total));
    chk({tag, "_sat_seen"}, 32'(sat_seen), 32'(exp_sat));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset_n = 1'b0;
    start   = 1'b0;
    clear_map();
    #23;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mine_re", 32'(mine_re), 32'd0);
    chk("rst_cell_we", 32'(cell_we), 32'd0);
    chk("rst_mine_addr", 32'(mine_addr), 32'd0);
    chk("rst_cell_addr", 32'(cell_addr), 32'd0);
    chk("rst_cell_wdata", 32'(cell_wdata), 32'd0);
    chk("rst_mine_total", 32'(mine_total), 32'd0);
    chk("rst_sat_seen", 32'(sat_seen), 32'd0);
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // 1: empty board
    do_scan("empty", 0, 0, 0, 1'b0);
    chk("empty_c0", 32'(got[0]), 32'h00);
    chk("empty_c255", 32'(got[255]), 32'h00);

    // 2: single corner mine
    clear_map();
    map[0] = 1'b1;
    do_scan("corner", 0, 0, 1, 1'b0);
    chk("corner_c0", 32'(got[0]), 32'b01000);
    chk("corner_c1", 32'(got[1]), 32'b00001);
    chk("corner_c16", 32'(got[16]), 32'b00001);
    chk("corner_c17", 32'(got[17]), 32'b00001);
    chk("corner_c2", 32'(got[2]), 32'b00000);

    // 3: three mines around the corner
    clear_map();
    map[1] = 1'b1; map[16] = 1'b1; map[17] = 1'b1;
    do_scan("three", 0, 0, 3, 1'b0);
    chk("three_c0", 32'(got[0]), 32'b00011);
    chk("three_c1", 32'(got[1]), 32'b01000);
    chk("three_c2", 32'(got[2]), 32'b00010);
    chk("three_c34", 32'(got[34]), 32'b00001);

    // 4: full ring around (7,7)
    clear_map();
    map[102] = 1'b1; map[103] = 1'b1; map[104] = 1'b1; map[118] = 1'b1;
    map[120] = 1'b1; map[134] = 1'b1; map[135] = 1'b1; map[136] = 1'b1;
    do_scan("ring", 0, 0, 8, 1'b1);
    chk("ring_c119", 32'(got[119]), 32'b00111);
    chk("ring_c102", 32'(got[102]), 32'b01000);
    chk("ring_c136", 32'(got[136]), 32'b01000);

    // 5: every cell a mine (also shows sat_seen cleared by start)
    for (int i = 0; i < 256; i++) map[i] = 1'b1;
    do_scan("allmine", 0, 0, 256, 1'b0);
    chk("allmine_c0", 32'(got[0]), 32'b01000);
    chk("allmine_c137", 32'(got[137]), 32'b01000);

    // 6: stray start at cycle 100 is ignored
    clear_map();
    do_scan("poke", 100, 0, 0, 1'b0);

    // 7: reset at cycle 500, then a clean rescan
    map[1] = 1'b1; map[16] = 1'b1; map[17] = 1'b1;
    do_scan("abort", 0, 500, 0, 1'b0);
    @(posedge Clk);
    #1;
    do_scan("rescan", 0, 0, 3, 1'b0);
    chk("rescan_c0", 32'(got[0]), 32'b00011);
    chk("rescan_c34", 32'(got[34]), 32'b00001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
